// File: rtl/mips_reg_file.sv
// 32 x 32-bit MIPS general-purpose register file: two combinational read ports,
// one synchronous write port, optional same-cycle write-through to the readers.
module mips_reg_file #(
  parameter bit          BYPASS  = 1'b1,
  parameter logic [31:0] SP_INIT = 32'h0000_3FFC,
  parameter logic [31:0] GP_INIT = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWrite,
  input  logic [4:0]  WriteReg,
  input  logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2
);

  localparam int unsigned NREGS  = 32;
  localparam int unsigned GP_IDX = 28;
  localparam int unsigned SP_IDX = 29;

  logic [31:0] regs_q [NREGS];
  logic [31:0] regs_d [NREGS];
  logic        wr_en;
  logic        byp_en;

  // Register 0 is never a write target; its slot is pinned to zero.
  assign wr_en = RegWrite && (WriteReg != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[0] = '0;
  end

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        if (i == GP_IDX) begin
          regs_q[i] <= GP_INIT;
        end else if (i == SP_IDX) begin
          regs_q[i] <= SP_INIT;
        end else begin
          regs_q[i] <= '0;
        end
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Forwarding is disabled while reset is high, since that write never lands.
  assign byp_en = BYPASS && RegWrite && !reset;

  always_comb begin
    ReadData1 = '0;
    if (ReadReg1 != 5'd0) begin
      if (byp_en && (ReadReg1 == WriteReg)) begin
        ReadData1 = WriteData;
      end else begin
        ReadData1 = regs_q[ReadReg1];
      end
    end
  end

  always_comb begin
    ReadData2 = '0;
    if (ReadReg2 != 5'd0) begin
      if (byp_en && (ReadReg2 == WriteReg)) begin
        ReadData2 = WriteData;
      end else begin
        ReadData2 = regs_q[ReadReg2];
      end
    end
  end

endmodule
